// File: rtl/tone_square_gen.sv
//==============================================================================
// Module      : tone_square_gen
// Description : Tone-to-square-wave sink. Converts a frequency in Hz to a
//               half-period using an iterative restoring divider and drives a
//               1-bit square wave. Optional macro VOLUME_EN adds a 3-bit
//               volume input that narrows the high phase of the wave.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tone_square_gen #(
  parameter logic [31:0] CLK_HZ     = 32'd100_000_000,
  parameter logic [31:0] SILENCE_HZ = 32'd20000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] tone,
`ifdef VOLUME_EN
  input  logic [2:0]  volume,
`endif
  output logic        audio_out,
  output logic        busy,
  output logic [31:0] half_period
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DIV  = 2'd1,
    RUN  = 2'd2
  } state_t;

  state_t      state;
  logic [31:0] tone_q;
  logic [31:0] dvd;
  logic [32:0] dsr;
  logic [32:0] rem;
  logic [31:0] quo;
  logic [4:0]  step;
  logic [31:0] cnt;
  logic        phase;

  logic [33:0] rem_sh;
  logic        rem_ge;
  logic [33:0] rem_sub;
  logic [32:0] rem_nx;
  logic [31:0] quo_nx;
  logic        tone_silent;

  // One restoring step: shift in the next dividend bit, subtract if it fits.
  always_comb begin
    rem_sh      = {rem, dvd[31]};
    rem_ge      = (rem_sh >= {1'b0, dsr});
    rem_sub     = rem_sh - {1'b0, dsr};
    rem_nx      = rem_ge ? rem_sub[32:0] : rem_sh[32:0];
    quo_nx      = {quo[30:0], rem_ge};
    tone_silent = (tone == 32'd0) || (tone >= SILENCE_HZ);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      tone_q      <= 32'd0;
      dvd         <= 32'd0;
      dsr         <= 33'd0;
      rem         <= 33'd0;
      quo         <= 32'd0;
      step        <= 5'd0;
      cnt         <= 32'd0;
      phase       <= 1'b0;
      busy        <= 1'b0;
      half_period <= 32'd0;
    end else begin
      // The waveform keeps running on the current half_period while dividing.
      if (half_period == 32'd0) begin
        cnt   <= 32'd0;
        phase <= 1'b0;
      end else if (cnt == half_period - 32'd1) begin
        cnt   <= 32'd0;
        phase <= ~phase;
      end else begin
        cnt <= cnt + 32'd1;
      end

      if (tone != tone_q) begin
        tone_q <= tone;
        if (tone_silent) begin
          half_period <= 32'd0;
          busy        <= 1'b0;
          cnt         <= 32'd0;
          phase       <= 1'b0;
          state       <= IDLE;
        end else begin
          dvd   <= CLK_HZ;
          dsr   <= {tone, 1'b0};
          rem   <= 33'd0;
          quo   <= 32'd0;
          step  <= 5'd0;
          busy  <= 1'b1;
          state <= DIV;
        end
      end else if (state == DIV) begin
        dvd  <= {dvd[30:0], 1'b0};
        rem  <= rem_nx;
        quo  <= quo_nx;
        step <= step + 5'd1;
        if (step == 5'd31) begin
          half_period <= (quo_nx == 32'd0) ? 32'd1 : quo_nx;
          busy        <= 1'b0;
          cnt         <= 32'd0;
          phase       <= phase;
          state       <= RUN;
        end
      end
    end
  end

`ifdef VOLUME_EN
  logic [34:0] vol_thresh;

  always_comb begin
    vol_thresh = 35'(half_period >> 3) * (35'(volume) + 35'd1);
    audio_out  = phase && ({3'b000, cnt} < vol_thresh);
  end
`else
  assign audio_out = phase;
`endif

endmodule

`default_nettype wire
